// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the external memory bus sequencer/arbiter.
// The state encoding is visible on state_dbg, so its values are part of the interface.
package mem_bus_pkg;

   typedef enum logic [3:0] {
      StIdle    = 4'd0,
      StAddr    = 4'd1,
      StLatch   = 4'd2,
      StRdOe    = 4'd3,
      StRdCap   = 4'd4,
      StWrData  = 4'd5,
      StWrPulse = 4'd6,
      StWrHold  = 4'd7,
      StAck     = 4'd8
   } state_e;

   localparam logic [7:0] OUT_ADDR_DEFAULT = 8'hFF;

   localparam int unsigned CPU = 0;
   localparam int unsigned LDR = 1;

   typedef struct packed {
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
   } txn_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; the last-granted pointer advances only on accept.
module rr_arb2
   import mem_bus_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   // 1 = loader was granted last; resets to loader so the core wins the first tie
   logic last_q, last_d;

   always_comb begin
      if (req == 2'b11) begin
         gnt = last_q ? 2'b01 : 2'b10;
      end else begin
         gnt = req;
      end
   end

   always_comb begin
      last_d = last_q;
      if (accept && (gnt != 2'b00)) begin
         last_d = gnt[LDR];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shared memory bus sequencer: arbitrates core/loader byte requests and runs the
// latch-then-access strobe sequence. Outputs are registered from the next state.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter logic [7:0] OUT_ADDR = OUT_ADDR_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cpu_req,
   input  logic       cpu_we,
   input  logic [7:0] cpu_addr,
   input  logic [7:0] cpu_wdata,
   output logic       cpu_ack,
   output logic [7:0] cpu_rdata,
   input  logic       ldr_req,
   input  logic       ldr_we,
   input  logic [7:0] ldr_addr,
   input  logic [7:0] ldr_wdata,
   output logic       ldr_ack,
   output logic [7:0] ldr_rdata,
   input  logic [7:0] bus_in,
   output logic [7:0] bus_out,
   output logic       bus_oe,
   output logic       latch_clk,
   output logic       sram_oe_n,
   output logic       sram_we_n,
   output logic       out_latch_clk,
   output logic       grant_ldr,
   output logic [3:0] state_dbg
);

   state_e     state_q, state_d;
   txn_t       txn_q, txn_d;
   logic       grant_ldr_q, grant_ldr_d;
   logic [1:0] gnt;
   logic       accept;

   logic       bus_oe_q, bus_oe_d;
   logic [7:0] bus_out_q, bus_out_d;
   logic       latch_clk_q, latch_clk_d;
   logic       sram_oe_n_q, sram_oe_n_d;
   logic       sram_we_n_q, sram_we_n_d;
   logic       out_latch_clk_q, out_latch_clk_d;
   logic       cpu_ack_q, cpu_ack_d;
   logic       ldr_ack_q, ldr_ack_d;
   logic [7:0] cpu_rdata_q, cpu_rdata_d;
   logic [7:0] ldr_rdata_q, ldr_rdata_d;

   assign accept = (state_q == StIdle) && (cpu_req || ldr_req);

   rr_arb2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    ({ldr_req, cpu_req}),
      .accept (accept),
      .gnt    (gnt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         txn_q       <= '0;
         grant_ldr_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         txn_q       <= txn_d;
         grant_ldr_q <= grant_ldr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      txn_d       = txn_q;
      grant_ldr_d = grant_ldr_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d     = StAddr;
               grant_ldr_d = gnt[LDR];
               if (gnt[LDR]) begin
                  txn_d.we    = ldr_we;
                  txn_d.addr  = ldr_addr;
                  txn_d.wdata = ldr_wdata;
               end else begin
                  txn_d.we    = cpu_we;
                  txn_d.addr  = cpu_addr;
                  txn_d.wdata = cpu_wdata;
               end
            end
         end
         StAddr:    state_d = StLatch;
         StLatch:   state_d = txn_q.we ? StWrData : StRdOe;
         StRdOe:    state_d = StRdCap;
         StRdCap:   state_d = StAck;
         StWrData:  state_d = StWrPulse;
         StWrPulse: state_d = StWrHold;
         StWrHold:  state_d = StAck;
         StAck:     state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Output values are decoded from the state being entered so they register with it
   always_comb begin
      bus_oe_d        = 1'b1;
      bus_out_d       = bus_out_q;
      latch_clk_d     = 1'b0;
      sram_oe_n_d     = 1'b1;
      sram_we_n_d     = 1'b1;
      out_latch_clk_d = 1'b0;
      cpu_ack_d       = 1'b0;
      ldr_ack_d       = 1'b0;
      cpu_rdata_d     = cpu_rdata_q;
      ldr_rdata_d     = ldr_rdata_q;
      unique case (state_d)
         StAddr:  bus_out_d = txn_d.addr;
         StLatch: latch_clk_d = 1'b1;
         StRdOe, StRdCap: begin
            latch_clk_d = 1'b1;
            bus_oe_d    = 1'b0;
            sram_oe_n_d = 1'b0;
         end
         StWrData: begin
            latch_clk_d = 1'b1;
            bus_out_d   = txn_d.wdata;
         end
         StWrPulse: begin
            latch_clk_d = 1'b1;
            if (txn_d.addr != OUT_ADDR) begin
               sram_we_n_d = 1'b0;
            end else begin
               out_latch_clk_d = 1'b1;
            end
         end
         StWrHold: latch_clk_d = 1'b1;
         StAck: begin
            latch_clk_d = 1'b1;
            cpu_ack_d   = !grant_ldr_d;
            ldr_ack_d   = grant_ldr_d;
         end
         default: ;
      endcase
      if (state_q == StRdCap) begin
         if (grant_ldr_q) begin
            ldr_rdata_d = bus_in;
         end else begin
            cpu_rdata_d = bus_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus_oe_q        <= 1'b1;
         bus_out_q       <= 8'h00;
         latch_clk_q     <= 1'b0;
         sram_oe_n_q     <= 1'b1;
         sram_we_n_q     <= 1'b1;
         out_latch_clk_q <= 1'b0;
         cpu_ack_q       <= 1'b0;
         ldr_ack_q       <= 1'b0;
         cpu_rdata_q     <= 8'h00;
         ldr_rdata_q     <= 8'h00;
      end else begin
         bus_oe_q        <= bus_oe_d;
         bus_out_q       <= bus_out_d;
         latch_clk_q     <= latch_clk_d;
         sram_oe_n_q     <= sram_oe_n_d;
         sram_we_n_q     <= sram_we_n_d;
         out_latch_clk_q <= out_latch_clk_d;
         cpu_ack_q       <= cpu_ack_d;
         ldr_ack_q       <= ldr_ack_d;
         cpu_rdata_q     <= cpu_rdata_d;
         ldr_rdata_q     <= ldr_rdata_d;
      end
   end

   assign bus_oe        = bus_oe_q;
   assign bus_out       = bus_out_q;
   assign latch_clk     = latch_clk_q;
   assign sram_oe_n     = sram_oe_n_q;
   assign sram_we_n     = sram_we_n_q;
   assign out_latch_clk = out_latch_clk_q;
   assign cpu_ack       = cpu_ack_q;
   assign ldr_ack       = ldr_ack_q;
   assign cpu_rdata     = cpu_rdata_q;
   assign ldr_rdata     = ldr_rdata_q;
   assign grant_ldr     = grant_ldr_q;
   assign state_dbg     = state_q;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequencer and two-way arbiter for the shared external memory bus: the 8-bit bidirectional data bus, the address latch, the SRAM OE/WE strobes and the output latch. It accepts byte read and write requests from the SUBNEG core port and from a program-loader/debug port. It grants one requester at a time, round-robin, and runs the fixed latch-then-access strobe sequence for the granted request. It sits between the core and loader and the top-level uio/uo pins.

## Interface
Parameters:
- `OUT_ADDR`, default 8'hFF: a write to this address pulses the output latch instead of the SRAM.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `cpu_req`  in  1  core request; held high until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read; sampled at grant.
- `cpu_addr`  in  8  address; sampled at grant.
- `cpu_wdata`  in  8  write data; sampled at grant.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  8  read data; valid while `cpu_ack`=1, held afterwards.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_ack`, `ldr_rdata`: loader port, same semantics as the core port.
- `bus_in`  in  8  data bus input (uio_in).
- `bus_out`  out  8  data bus drive value (uio_out).
- `bus_oe`  out  1  1 = chip drives the bus; replicated to all 8 uio_oe bits at top level.
- `latch_clk`  out  1  address latch clock; the rising edge captures `bus_out`.
- `sram_oe_n`  out  1  SRAM output enable, active low.
- `sram_we_n`  out  1  SRAM write enable, active low.
- `out_latch_clk`  out  1  output latch clock.
- `grant_ldr`  out  1  1 = loader owns the current or most recent transaction.
- `state_dbg`  out  4  encoded FSM state for uo_out debug.

## Operation
- **States:** IDLE, ADDR, LATCH, RD_OE, RD_CAP, WR_DATA, WR_PULSE, WR_HOLD, ACK.
- **IDLE:** if any request is pending, the arbiter picks one, and on that edge the FSM latches its we/addr/wdata internally and moves to ADDR. Otherwise it stays in IDLE.
- **Arbitration:** round-robin with a last-granted pointer, which resets to loader so the core wins the first tie. A sole requester is always granted. After a grant, the other requester wins the next tie.
- **ADDR:** `bus_oe`=1, `bus_out`=addr, `latch_clk`=0.
- **LATCH:** `latch_clk`=1. `latch_clk` stays 1 through ACK and returns to 0 in IDLE.
- **Read path:**
  - RD_OE: `bus_oe`=0, `sram_oe_n`=0.
  - RD_CAP: capture `bus_in` into the granted port's rdata register.
  - ACK: `sram_oe_n`=1, `bus_oe`=1.
- **Write path:**
  - WR_DATA: `bus_out`=wdata.
  - WR_PULSE: if addr≠`OUT_ADDR`, `sram_we_n`=0; else `out_latch_clk`=1.
  - WR_HOLD: both strobes deasserted; data still driven.
  - ACK.
- **ACK:** the granted port's ack is 1 for exactly this cycle, then the FSM returns to IDLE.
- A read from `OUT_ADDR` is an ordinary SRAM read.
- A request deasserted mid-transaction does not abort it; the ack still fires.
- A new request is never granted before IDLE is re-entered.
- **Invariants:**
  - `sram_oe_n`=0 only when `bus_oe`=0.
  - `sram_we_n`=0 and `out_latch_clk`=1 are never simultaneous.
  - `sram_we_n`=0 only when `bus_oe`=1.
  - Never both acks at once.

## Timing
- All outputs are registered.
- Reset values: `bus_oe`=1, `bus_out`=0, `latch_clk`=0, `sram_oe_n`=1, `sram_we_n`=1, `out_latch_clk`=0, both acks 0, both rdata 0, `grant_ldr`=0, state IDLE.
- Grant edge = the edge on which IDLE samples the request.
- Read latency: ack high in the 5th cycle after the grant edge (ADDR, LATCH, RD_OE, RD_CAP, ACK).
- Write latency: ack high in the 6th cycle after the grant edge.
- Back-to-back throughput: one read per 6 cycles, one write per 7 cycles, because IDLE takes one cycle.
- Reset asserted mid-transaction: at the next edge all outputs take their reset values. No ack is issued, and the pointer resets.
- Both requests arriving in the same cycle: a single grant per the pointer; the loser waits, holding its request.

## Structure
- Package `mem_bus_pkg`:
  - state enum (4-bit encoding, shared with `state_dbg` decode in the bench);
  - `OUT_ADDR_DEFAULT`;
  - port index constants CPU=0, LDR=1.
- One sub-module, `rr_arb2`: a two-request round-robin arbiter with a pointer update on an `accept` strobe.

## Test plan
- Reset, then idle 10 cycles -> all outputs at reset values, no ack.
- Core read of 8'h10 with the bench SRAM model holding 8'h5A -> `latch_clk` rises with `bus_out`=8'h10; `cpu_ack` 5 cycles after the grant edge with `cpu_rdata`=8'h5A; `sram_oe_n` low exactly 2 cycles.
- Loader write 8'h33 to 8'h20 -> one `sram_we_n` low cycle with `bus_out`=8'h33 and `bus_oe`=1; a later core read of 8'h20 returns 8'h33.
- Core write 8'hC3 to 8'hFF -> one `out_latch_clk` pulse with `bus_out`=8'hC3, `sram_we_n` never low, `cpu_ack` at cycle 6.
- `cpu_req` and `ldr_req` asserted together and held for 4 transactions -> grants alternate CPU, LDR, CPU, LDR; acks never overlap.
- Reset asserted in the RD_OE cycle -> next cycle `sram_oe_n`=1, `bus_oe`=1, no ack; a fresh request after reset completes normally.
